uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between `N_REQ` firmware modules that return data to the host, such as sample dumpers and status reporters. Requesters present bytes through a simple req/ack handshake. The arbiter grants one requester at a time in round-robin order, holds that grant for a burst, and sequences each byte into the transmitter through a start/busy handshake. It is the transmit-side counterpart of the per-module command watchers on the receive path.

---
 rtl/tx_arb_pkg.sv | 38 +++
 rtl/rr_picker.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arb_pkg.sv
// rtl/tx_arb_pkg.sv - shared types and round-robin pick function for the UART transmit arbiter
package tx_arb_pkg;

    localparam int TX_ARB_MAX_N = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HDR       = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_RISE = 3'd3,
        ST_WAIT_FALL = 3'd4
    } tx_arb_state_t;

    // First set bit of req at or after ptr, wrapping modulo n; one-hot result, zero when none.
    function automatic logic [TX_ARB_MAX_N-1:0] rr_pick(
        input logic [TX_ARB_MAX_N-1:0] req,
        input logic [2:0]              ptr,
        input int                      n
    );
        logic [TX_ARB_MAX_N-1:0] pick;
        logic                    found;
        logic [3:0]              idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < TX_ARB_MAX_N; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(n)) begin
                idx = idx - 4'(n);
            end
            if ((k < n) && !found && req[idx[2:0]]) begin
                pick[idx[2:0]] = 1'b1;
                found          = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin one-hot selector with binary index
module rr_picker #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [N_REQ-1:0]         pick,
    output logic [$clog2(N_REQ)-1:0] pick_idx
);
    import tx_arb_pkg::*;

    localparam int PW = $clog2(N_REQ);

    logic [TX_ARB_MAX_N-1:0] req_w;
    logic [TX_ARB_MAX_N-1:0] pick_w;
    logic [2:0]              ptr_w;

    always_comb begin
        req_w              = '0;
        req_w[N_REQ-1:0]   = req;
        ptr_w              = '0;
        ptr_w[PW-1:0]      = rr_ptr;
        pick_w             = rr_pick(req_w, ptr_w, N_REQ);
        pick               = pick_w[N_REQ-1:0];
        pick_idx           = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_w[i]) begin
                pick_idx = PW'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin burst arbiter feeding one UART transmitter
// Optional per-burst ID header byte enabled by defining TX_ARB_HEADER_EN.
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16
`ifdef TX_ARB_HEADER_EN
    ,
    parameter logic [7:0] ID_BASE = 8'h01
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ack,
    output logic [N_REQ-1:0]   grant,
    output logic               active,
    input  logic               Tx_busy,
    output logic               Tx_start,
    output logic [7:0]         Tx_data
);
    import tx_arb_pkg::*;

    localparam int         PW    = $clog2(N_REQ);
    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    tx_arb_state_t    state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [7:0]       burst_cnt_q, burst_cnt_d;
    logic             last_q, last_d;
    logic             active_q;
    logic [7:0]       tx_data_q;
`ifdef TX_ARB_HEADER_EN
    logic             hdr_q, hdr_d;
`endif

    logic [N_REQ-1:0] pick;
    logic [PW-1:0]    pick_idx;
    logic             owner_req;
    logic [7:0]       owner_data;
    logic             release_now;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req      (req),
        .rr_ptr   (rr_ptr_q),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    assign owner_req  = req[owner_q];
    assign owner_data = req_data[{owner_q, 3'b000} +: 8];

`ifdef TX_ARB_HEADER_EN
    // After the header the only reason to keep the grant is a payload byte still waiting.
    assign release_now = hdr_q ? !owner_req
                               : (last_q || (burst_cnt_q == MAX_B) || !owner_req);
`else
    assign release_now = last_q || (burst_cnt_q == MAX_B) || !owner_req;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        last_d      = last_q;
        req_ack     = '0;
        Tx_start    = 1'b0;
        Tx_data     = tx_data_q;
`ifdef TX_ARB_HEADER_EN
        hdr_d       = hdr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A frame still shifting (e.g. after reset) must finish before any new start.
                if ((|req) && !Tx_busy) begin
                    grant_d     = pick;
                    owner_d     = pick_idx;
                    burst_cnt_d = '0;
`ifdef TX_ARB_HEADER_EN
                    state_d     = ST_HDR;
`else
                    state_d     = ST_SEND;
`endif
                end
            end
`ifdef TX_ARB_HEADER_EN
            ST_HDR: begin
                Tx_start = 1'b1;
                Tx_data  = ID_BASE + 8'(owner_q);
                hdr_d    = 1'b1;
                state_d  = ST_WAIT_RISE;
            end
`endif
            ST_SEND: begin
                Tx_start = 1'b1;
                Tx_data  = owner_data;
                req_ack  = grant_q;
                last_d   = req_last[owner_q];
                if (burst_cnt_q != MAX_B) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
`ifdef TX_ARB_HEADER_EN
                hdr_d    = 1'b0;
`endif
                state_d  = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (Tx_busy) begin
                    state_d = ST_WAIT_FALL;
                end
            end
            ST_WAIT_FALL: begin
                if (!Tx_busy) begin
                    if (release_now) begin
                        grant_d  = '0;
                        rr_ptr_d = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            last_q      <= 1'b0;
            active_q    <= 1'b0;
            tx_data_q   <= 8'h00;
`ifdef TX_ARB_HEADER_EN
            hdr_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            last_q      <= last_d;
            active_q    <= (state_d != ST_IDLE);
            tx_data_q   <= Tx_data;
`ifdef TX_ARB_HEADER_EN
            hdr_q       <= hdr_d;
`endif
        end
    end

    assign grant  = grant_q;
    assign active = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int MAXB     = 16;
    localparam int BUSY_LEN = 10;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   grant;
    logic           active;
    logic           Tx_busy;
    logic           Tx_start;
    logic [7:0]     Tx_data;

    int total = 0;
    int bad   = 0;

    int         rq_total[N];
    logic [7:0] rq_base[N];
    int         rq_last_at[N];
    logic       rq_last_all[N];
    logic       rq_drop[N];
    int         ack_cnt[N] = '{0, 0, 0, 0};
    int         busy_cnt = 0;
    logic [7:0] tx_log[$];
    int         gnt_log[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MAXB)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .req_ack  (req_ack),
        .grant    (grant),
        .active   (active),
        .Tx_busy  (Tx_busy),
        .Tx_start (Tx_start),
        .Tx_data  (Tx_data)
    );

    always_comb begin
        req      = '0;
        req_data = '0;
        req_last = '0;
        for (int i = 0; i < N; i++) begin
            req[i]            = !rq_drop[i] && (ack_cnt[i] < rq_total[i]);
            req_data[8*i +: 8] = rq_base[i] + 8'(ack_cnt[i]);
            req_last[i]       = rq_last_all[i] || ((ack_cnt[i] + 1) == rq_last_at[i]);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (req_ack[i]) ack_cnt[i] <= ack_cnt[i] + 1;
        end
    end

    always @(posedge clk) begin
        if (Tx_start)          busy_cnt <= BUSY_LEN;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign Tx_busy = (busy_cnt != 0);

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = (r == -1) ? i : -2;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (Tx_start) begin
            tx_log.push_back(Tx_data);
            gnt_log.push_back(oh_idx(grant));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output logic ok);
        int c = 0;
        ok = 1'b0;
        while (c < budget) begin
            @(negedge clk);
            if (req == '0 && grant == '0 && !active && !Tx_busy) begin
                ok = 1'b1;
                break;
            end
            c++;
        end
    endtask

    task automatic wait_starts(input int target, input int budget, output logic ok);
        int c = 0;
        ok = 1'b0;
        while (c < budget) begin
            @(negedge clk);
            #1;
            if (tx_log.size() >= target) begin
                ok = 1'b1;
                break;
            end
            c++;
        end
    endtask

    task automatic wait_busy(input logic level, input int budget, output logic ok);
        int c = 0;
        ok = 1'b0;
        while (c < budget) begin
            @(negedge clk);
            if (Tx_busy == level) begin
                ok = 1'b1;
                break;
            end
            c++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", active); end
        total++; if (req_ack !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b exp=0000", req_ack); end
        total++; if (Tx_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", Tx_start); end
        total++; if (Tx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", Tx_data); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int n0;
        int a0;
        logic ok;
        n0 = tx_log.size();
        a0 = ack_cnt[0];
        rq_base[0]    = 8'hA1 - 8'(a0);
        rq_last_at[0] = a0 + 3;
        rq_total[0]   = a0 + 3;
        @(negedge clk);
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant_c1 got=%b exp=0001", grant); end
        total++; if (Tx_start !== 1'b1) begin bad++; $display("FAIL single_start_c1 got=%b exp=1", Tx_start); end
        total++; if (Tx_data !== 8'hA1) begin bad++; $display("FAIL single_data_c1 got=%h exp=a1", Tx_data); end
        total++; if (req_ack !== 4'b0001) begin bad++; $display("FAIL single_ack_c1 got=%b exp=0001", req_ack); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL single_active_c1 got=%b exp=1", active); end
        wait_starts(n0 + 3, 200, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_starts got=%0d exp=%0d", tx_log.size() - n0, 3); end
        wait_busy(1'b1, 20, ok);
        wait_busy(1'b0, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_busy_fall got=timeout exp=fall"); end
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant_at_fall got=%b exp=0001", grant); end
        @(negedge clk);
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL single_grant_released got=%b exp=0000", grant); end
        total++; if (tx_log[n0] !== 8'hA1) begin bad++; $display("FAIL single_byte0 got=%h exp=a1", tx_log[n0]); end
        total++; if (tx_log[n0+1] !== 8'hA2) begin bad++; $display("FAIL single_byte1 got=%h exp=a2", tx_log[n0+1]); end
        total++; if (tx_log[n0+2] !== 8'hA3) begin bad++; $display("FAIL single_byte2 got=%h exp=a3", tx_log[n0+2]); end
        total++; if (ack_cnt[0] - a0 != 3) begin bad++; $display("FAIL single_acks got=%0d exp=3", ack_cnt[0] - a0); end
    endtask

    task automatic test_rr_all();
        int n0;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic ok;
        do_reset();
        n0 = tx_log.size();
        for (int i = 0; i < N; i++) begin
            rq_last_all[i] = 1'b1;
            rq_base[i]     = 8'h30 + 8'(i) - 8'(ack_cnt[i]);
            rq_total[i]    = ack_cnt[i] + ((i == 0) ? 2 : 1);
        end
        wait_idle(600, ok);
        total++; if (!ok) begin bad++; $display("FAIL rr_idle got=timeout exp=idle"); end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (gnt_log[n0+k] !== exp_order[k]) begin
                bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, gnt_log[n0+k], exp_order[k]);
            end
        end
        for (int i = 0; i < N; i++) rq_last_all[i] = 1'b0;
    endtask

    task automatic test_max_burst();
        int n0;
        int a2;
        int run2;
        logic ok;
        n0 = tx_log.size();
        a2 = ack_cnt[2];
        rq_last_at[2]  = 0;
        rq_base[2]     = 8'h10 - 8'(a2);
        rq_total[2]    = a2 + 20;
        rq_last_all[3] = 1'b1;
        rq_base[3]     = 8'hC3 - 8'(ack_cnt[3]);
        rq_total[3]    = ack_cnt[3] + 1;
        wait_idle(800, ok);
        total++; if (!ok) begin bad++; $display("FAIL burst_idle got=timeout exp=idle"); end
        run2 = 0;
        for (int k = 0; k < 16; k++) if (gnt_log[n0+k] == 2) run2++;
        total++; if (run2 != 16) begin bad++; $display("FAIL burst_first16_owner got=%0d exp=16", run2); end
        total++; if (gnt_log[n0+16] !== 3) begin bad++; $display("FAIL burst_next_owner got=%0d exp=3", gnt_log[n0+16]); end
        total++; if (tx_log[n0+15] !== 8'h1F) begin bad++; $display("FAIL burst_byte16 got=%h exp=1f", tx_log[n0+15]); end
        total++; if (tx_log[n0+16] !== 8'hC3) begin bad++; $display("FAIL burst_r3_byte got=%h exp=c3", tx_log[n0+16]); end
        total++; if (gnt_log[n0+17] !== 2) begin bad++; $display("FAIL burst_resume_owner got=%0d exp=2", gnt_log[n0+17]); end
        total++; if (tx_log[n0+17] !== 8'h20) begin bad++; $display("FAIL burst_resume_byte got=%h exp=20", tx_log[n0+17]); end
        total++; if (tx_log.size() - n0 != 21) begin bad++; $display("FAIL burst_frames got=%0d exp=21", tx_log.size() - n0); end
        total++; if (ack_cnt[2] - a2 != 20) begin bad++; $display("FAIL burst_acks got=%0d exp=20", ack_cnt[2] - a2); end
        rq_last_all[3] = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int n0;
        int a1;
        int starts_busy;
        int c;
        logic ok;
        n0 = tx_log.size();
        a1 = ack_cnt[1];
        rq_base[1]    = 8'h70 - 8'(a1);
        rq_last_at[1] = a1 + 2;
        rq_total[1]   = a1 + 2;
        wait_starts(n0 + 1, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_first_start got=timeout exp=start"); end
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL mid_grant got=%b exp=0000", grant); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL mid_active got=%b exp=0", active); end
        total++; if (req_ack !== 4'b0000 || Tx_start !== 1'b0) begin bad++; $display("FAIL mid_pulses got=%b/%b exp=0000/0", req_ack, Tx_start); end
        total++; if (Tx_data !== 8'h00) begin bad++; $display("FAIL mid_data got=%h exp=00", Tx_data); end
        @(negedge clk);
        reset = 1'b0;
        starts_busy = 0;
        c = 0;
        while (Tx_busy && c < 30) begin
            @(negedge clk);
            if (Tx_start && Tx_busy) starts_busy++;
            c++;
        end
        total++; if (starts_busy != 0 || c >= 30) begin bad++; $display("FAIL mid_start_while_busy got=%0d exp=0", starts_busy); end
        wait_idle(100, ok);
        total++; if (tx_log.size() - n0 != 2) begin bad++; $display("FAIL mid_frames got=%0d exp=2", tx_log.size() - n0); end
        total++; if (tx_log[n0+1] !== 8'h71) begin bad++; $display("FAIL mid_represent got=%h exp=71", tx_log[n0+1]); end
        total++; if (ack_cnt[1] - a1 != 2) begin bad++; $display("FAIL mid_acks got=%0d exp=2", ack_cnt[1] - a1); end
    endtask

    task automatic test_drop();
        int n0;
        int a3;
        logic ok;
        n0 = tx_log.size();
        a3 = ack_cnt[3];
        rq_last_at[3] = 0;
        rq_base[3]    = 8'hD0 - 8'(a3);
        rq_total[3]   = a3 + 5;
        wait_starts(n0 + 1, 50, ok);
        repeat (3) @(negedge clk);
        rq_drop[3] = 1'b1;
        wait_busy(1'b0, 20, ok);
        total++; if (grant !== 4'b1000) begin bad++; $display("FAIL drop_grant_at_fall got=%b exp=1000", grant); end
        @(negedge clk);
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL drop_released got=%b exp=0000", grant); end
        repeat (30) @(negedge clk);
        total++; if (tx_log.size() - n0 != 1) begin bad++; $display("FAIL drop_frames got=%0d exp=1", tx_log.size() - n0); end
        total++; if (ack_cnt[3] - a3 != 1) begin bad++; $display("FAIL drop_acks got=%0d exp=1", ack_cnt[3] - a3); end
        rq_total[3] = ack_cnt[3];
        rq_drop[3]  = 1'b0;
    endtask

`ifdef TX_ARB_HEADER_EN
    task automatic test_header();
        int n0;
        int a1;
        logic ok;
        do_reset();
        n0 = tx_log.size();
        a1 = ack_cnt[1];
        rq_last_all[1] = 1'b1;
        rq_base[1]     = 8'h55 - 8'(a1);
        rq_total[1]    = a1 + 1;
        wait_idle(100, ok);
        total++; if (tx_log.size() - n0 != 2) begin bad++; $display("FAIL hdr_frames got=%0d exp=2", tx_log.size() - n0); end
        total++; if (tx_log[n0] !== 8'h02) begin bad++; $display("FAIL hdr_id got=%h exp=02", tx_log[n0]); end
        total++; if (tx_log[n0+1] !== 8'h55) begin bad++; $display("FAIL hdr_payload got=%h exp=55", tx_log[n0+1]); end
        total++; if (ack_cnt[1] - a1 != 1) begin bad++; $display("FAIL hdr_acks got=%0d exp=1", ack_cnt[1] - a1); end
        rq_last_all[1] = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) begin
            rq_total[i]    = 0;
            rq_base[i]     = 8'h00;
            rq_last_at[i]  = 0;
            rq_last_all[i] = 1'b0;
            rq_drop[i]     = 1'b0;
        end
        test_reset();
`ifdef TX_ARB_HEADER_EN
        test_header();
`else
        test_single();
        test_rr_all();
        test_max_burst();
        test_reset_midframe();
        test_drop();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
